rs_station_param: RTL and testbench

//  Parametrised reservation station for the out-of-order core. Holds up to DEPTH issued ops waiting on

---
 rtl/rs_station_param.sv | 245 ++++++++++++++++++++++++
 tb/tb_rs_station_param.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_station_param.sv
// Reservation station: holds up to DEPTH issued ops, snoops NUM_CDB result
// buses for missing operands and hands the oldest ready op to a functional
// unit through a registered valid/ready dispatch stage.
module rs_station_param #(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int IMM_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush,
  input  logic                        alloc_valid,
  input  logic [OP_W-1:0]             alloc_op,
  input  logic [TAG_W-1:0]            alloc_dest,
  input  logic [TAG_W-1:0]            alloc_qj,
  input  logic [TAG_W-1:0]            alloc_qk,
  input  logic [DATA_W-1:0]           alloc_vj,
  input  logic [DATA_W-1:0]           alloc_vk,
  input  logic [IMM_W-1:0]            alloc_imm,
  input  logic [DATA_W-1:0]           alloc_pc,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_dest,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_value,
  output logic                        exe_valid,
  input  logic                        exe_ready,
  output logic [OP_W-1:0]             exe_op,
  output logic [TAG_W-1:0]            exe_dest,
  output logic [DATA_W-1:0]           exe_vj,
  output logic [DATA_W-1:0]           exe_vk,
  output logic [IMM_W-1:0]            exe_imm,
  output logic [DATA_W-1:0]           exe_pc,
  output logic                        full,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Entry state. r_age[i][j] = 1 means entry i was allocated before entry j.
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_age [DEPTH];
  logic [OP_W-1:0]   r_op  [DEPTH];
  logic [TAG_W-1:0]  r_dest[DEPTH];
  logic [TAG_W-1:0]  r_qj  [DEPTH];
  logic [TAG_W-1:0]  r_qk  [DEPTH];
  logic [DATA_W-1:0] r_vj  [DEPTH];
  logic [DATA_W-1:0] r_vk  [DEPTH];
  logic [IMM_W-1:0]  r_imm [DEPTH];
  logic [DATA_W-1:0] r_pc  [DEPTH];
  logic [CNT_W-1:0]  r_count;

  // Dispatch register.
  logic              r_exe_valid;
  logic [OP_W-1:0]   r_exe_op;
  logic [TAG_W-1:0]  r_exe_dest;
  logic [DATA_W-1:0] r_exe_vj;
  logic [DATA_W-1:0] r_exe_vk;
  logic [IMM_W-1:0]  r_exe_imm;
  logic [DATA_W-1:0] r_exe_pc;

  logic [TAG_W-1:0]  w_cdb_tag[NUM_CDB];
  logic [DATA_W-1:0] w_cdb_val[NUM_CDB];
  logic [DEPTH-1:0]  w_ready;
  logic [DEPTH-1:0]  w_oldest;
  logic              w_found;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_load;
  logic              w_disp;
  logic              w_accept;
  logic [DEPTH-1:0]  w_hit_j;
  logic [DEPTH-1:0]  w_hit_k;
  logic [DATA_W-1:0] w_cap_j[DEPTH];
  logic [DATA_W-1:0] w_cap_k[DEPTH];
  logic [TAG_W-1:0]  w_new_qj;
  logic [TAG_W-1:0]  w_new_qk;
  logic [DATA_W-1:0] w_new_vj;
  logic [DATA_W-1:0] w_new_vk;

  for (genvar c = 0; c < NUM_CDB; c++) begin : g_cdb
    assign w_cdb_tag[c] = cdb_dest[c*TAG_W +: TAG_W];
    assign w_cdb_val[c] = cdb_value[c*DATA_W +: DATA_W];
  end

  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign exe_valid = r_exe_valid;
  assign exe_op    = r_exe_op;
  assign exe_dest  = r_exe_dest;
  assign exe_vj    = r_exe_vj;
  assign exe_vk    = r_exe_vk;
  assign exe_imm   = r_exe_imm;
  assign exe_pc    = r_exe_pc;

  assign w_load   = !r_exe_valid || exe_ready;
  assign w_disp   = w_load && w_found;
  assign w_accept = alloc_valid && !full;

  // An entry is ready once it is occupied and both operands have arrived.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++)
      w_ready[i] = r_busy[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
  end

  // Pick the ready entry that no other ready entry is older than.
  always_comb begin
    w_oldest  = '0;
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_oldest[i] = w_ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && w_ready[j] && r_age[j][i]) w_oldest[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++)
      if (w_oldest[i]) w_sel_idx = IDX_W'(i);
  end

  assign w_found = |w_ready;

  // Lowest-index free slot; descending scan so the smallest index wins.
  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
  end

  // Operand wakeup for stored entries; descending scan lets channel 0 win.
  always_comb begin
    w_hit_j = '0;
    w_hit_k = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cap_j[i] = '0;
      w_cap_k[i] = '0;
      for (int c = NUM_CDB-1; c >= 0; c--) begin
        if (r_busy[i] && w_cdb_tag[c] != '0 && r_qj[i] == w_cdb_tag[c]) begin
          w_hit_j[i] = 1'b1;
          w_cap_j[i] = w_cdb_val[c];
        end
        if (r_busy[i] && w_cdb_tag[c] != '0 && r_qk[i] == w_cdb_tag[c]) begin
          w_hit_k[i] = 1'b1;
          w_cap_k[i] = w_cdb_val[c];
        end
      end
    end
  end

  // Bypass a result broadcast in the same cycle into the op being allocated.
  always_comb begin
    w_new_qj = alloc_qj;
    w_new_vj = alloc_vj;
    w_new_qk = alloc_qk;
    w_new_vk = alloc_vk;
    for (int c = NUM_CDB-1; c >= 0; c--) begin
      if (w_cdb_tag[c] != '0 && alloc_qj == w_cdb_tag[c]) begin
        w_new_qj = '0;
        w_new_vj = w_cdb_val[c];
      end
      if (w_cdb_tag[c] != '0 && alloc_qk == w_cdb_tag[c]) begin
        w_new_qk = '0;
        w_new_vk = w_cdb_val[c];
      end
    end
  end

  // Control state: occupancy, age order, count and the dispatch register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_busy      <= '0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
      r_count     <= '0;
      r_exe_valid <= 1'b0;
      r_exe_op    <= '0;
      r_exe_dest  <= '0;
      r_exe_vj    <= '0;
      r_exe_vk    <= '0;
      r_exe_imm   <= '0;
      r_exe_pc    <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_busy      <= '0;
        r_count     <= '0;
        r_exe_valid <= 1'b0;
      end else begin
        if (w_disp) r_busy[w_sel_idx] <= 1'b0;
        if (w_accept) begin
          r_busy[w_free_idx] <= 1'b1;
          // New entry is younger than every other slot.
          for (int j = 0; j < DEPTH; j++) begin
            r_age[w_free_idx][j] <= 1'b0;
            r_age[j][w_free_idx] <= (IDX_W'(j) != w_free_idx);
          end
        end
        if (w_load) begin
          r_exe_valid <= w_found;
          if (w_found) begin
            r_exe_op   <= r_op[w_sel_idx];
            r_exe_dest <= r_dest[w_sel_idx];
            r_exe_vj   <= r_vj[w_sel_idx];
            r_exe_vk   <= r_vk[w_sel_idx];
            r_exe_imm  <= r_imm[w_sel_idx];
            r_exe_pc   <= r_pc[w_sel_idx];
          end
        end
        r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_disp);
      end
    end
  end

  // Entry payload: allocation writes and operand capture on wakeup.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is not reset; r_busy gates every use, so clearing
    // it would only add reset fan-out to a large array.
    if (rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_hit_j[i]) begin
          r_qj[i] <= '0;
          r_vj[i] <= w_cap_j[i];
        end
        if (w_hit_k[i]) begin
          r_qk[i] <= '0;
          r_vk[i] <= w_cap_k[i];
        end
      end
      if (w_accept) begin
        r_op[w_free_idx]   <= alloc_op;
        r_dest[w_free_idx] <= alloc_dest;
        r_qj[w_free_idx]   <= w_new_qj;
        r_qk[w_free_idx]   <= w_new_qk;
        r_vj[w_free_idx]   <= w_new_vj;
        r_vk[w_free_idx]   <= w_new_vk;
        r_imm[w_free_idx]  <= alloc_imm;
        r_pc[w_free_idx]   <= alloc_pc;
      end
    end
  end

endmodule

// File: tb/tb_rs_station_param.sv
// Self-checking bench for rs_station_param: directed scenarios plus random
// traffic, all compared against an in-order queue model of the station.
module tb_rs_station_param;

  localparam int DEPTH   = 16;
  localparam int NUM_CDB = 2;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 6;
  localparam int IMM_W   = 32;
  localparam int CNT_W   = $clog2(DEPTH+1);

  logic                      clk = 1'b0;
  logic                      rst, rdy, flush, alloc_valid, exe_ready;
  logic [OP_W-1:0]           alloc_op;
  logic [TAG_W-1:0]          alloc_dest, alloc_qj, alloc_qk;
  logic [DATA_W-1:0]         alloc_vj, alloc_vk, alloc_pc;
  logic [IMM_W-1:0]          alloc_imm;
  logic [NUM_CDB*TAG_W-1:0]  cdb_dest;
  logic [NUM_CDB*DATA_W-1:0] cdb_value;
  logic                      exe_valid, full;
  logic [OP_W-1:0]           exe_op;
  logic [TAG_W-1:0]          exe_dest;
  logic [DATA_W-1:0]         exe_vj, exe_vk, exe_pc;
  logic [IMM_W-1:0]          exe_imm;
  logic [CNT_W-1:0]          count;

  rs_station_param #(
    .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W),
    .DATA_W(DATA_W), .OP_W(OP_W), .IMM_W(IMM_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_op(alloc_op), .alloc_dest(alloc_dest),
    .alloc_qj(alloc_qj), .alloc_qk(alloc_qk), .alloc_vj(alloc_vj), .alloc_vk(alloc_vk),
    .alloc_imm(alloc_imm), .alloc_pc(alloc_pc),
    .cdb_dest(cdb_dest), .cdb_value(cdb_value),
    .exe_valid(exe_valid), .exe_ready(exe_ready),
    .exe_op(exe_op), .exe_dest(exe_dest), .exe_vj(exe_vj), .exe_vk(exe_vk),
    .exe_imm(exe_imm), .exe_pc(exe_pc), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest, qj, qk;
    logic [DATA_W-1:0] vj, vk, pc;
    logic [IMM_W-1:0]  imm;
  } ent_t;

  // Reference model: entries kept in allocation order, oldest at the front.
  ent_t m_q[$];
  ent_t m_exe;
  bit   m_exe_valid;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Resolve a source tag against the buses; the first matching channel wins.
  function automatic ent_t wake(input ent_t e);
    ent_t r = e;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (r.qj != 0 && r.qj == cdb_dest[c*TAG_W +: TAG_W]) begin
        r.qj = 0;
        r.vj = cdb_value[c*DATA_W +: DATA_W];
      end
      if (r.qk != 0 && r.qk == cdb_dest[c*TAG_W +: TAG_W]) begin
        r.qk = 0;
        r.vk = cdb_value[c*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int   sel = -1;
    bit   load, acc;
    ent_t e;
    if (!rdy) return;
    if (flush) begin
      m_q.delete();
      m_exe_valid = 0;
      return;
    end
    for (int i = 0; i < m_q.size(); i++)
      if (m_q[i].qj == 0 && m_q[i].qk == 0) begin sel = i; break; end
    load = !m_exe_valid || exe_ready;
    acc  = alloc_valid && (m_q.size() < DEPTH);
    for (int i = 0; i < m_q.size(); i++) m_q[i] = wake(m_q[i]);
    if (load) begin
      m_exe_valid = (sel >= 0);
      if (sel >= 0) begin
        m_exe = m_q[sel];
        m_q.delete(sel);
      end
    end
    if (acc) begin
      e.op = alloc_op;  e.dest = alloc_dest; e.qj = alloc_qj; e.qk = alloc_qk;
      e.vj = alloc_vj;  e.vk = alloc_vk;     e.imm = alloc_imm; e.pc = alloc_pc;
      m_q.push_back(wake(e));
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 64'(exe_valid), 64'(m_exe_valid));
    check({tag, ".count"}, 64'(count), 64'(m_q.size()));
    check({tag, ".full"},  64'(full),  64'(m_q.size() == DEPTH));
    if (m_exe_valid) begin
      check({tag, ".op"},   64'(exe_op),   64'(m_exe.op));
      check({tag, ".dest"}, 64'(exe_dest), 64'(m_exe.dest));
      check({tag, ".vj"},   64'(exe_vj),   64'(m_exe.vj));
      check({tag, ".vk"},   64'(exe_vk),   64'(m_exe.vk));
      check({tag, ".imm"},  64'(exe_imm),  64'(m_exe.imm));
      check({tag, ".pc"},   64'(exe_pc),   64'(m_exe.pc));
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0; alloc_valid = 1'b0;
    cdb_dest = '0; cdb_value = '0;
  endtask

  task automatic set_alloc(input logic [TAG_W-1:0] dest, input logic [TAG_W-1:0] qj,
                           input logic [TAG_W-1:0] qk, input logic [DATA_W-1:0] vj,
                           input logic [DATA_W-1:0] vk);
    alloc_valid = 1'b1;
    alloc_op    = OP_W'($urandom);
    alloc_dest  = dest;
    alloc_qj    = qj;
    alloc_qk    = qk;
    alloc_vj    = vj;
    alloc_vk    = vk;
    alloc_imm   = $urandom;
    alloc_pc    = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, 64'(exe_valid), 64'd0);
    check({tag, ".count"}, 64'(count),     64'd0);
    check({tag, ".full"},  64'(full),      64'd0);
    check({tag, ".payload"},
          64'(exe_op) | 64'(exe_dest) | 64'(exe_vj) | 64'(exe_vk) | 64'(exe_imm) | 64'(exe_pc),
          64'd0);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_exe_valid = 0;
    m_exe = '{default: '0};
  endtask

  logic [TAG_W-1:0] t0, t1;

  initial begin
    rst = 1'b1; exe_ready = 1'b1;
    idle();
    set_alloc(0, 0, 0, 0, 0);
    alloc_valid = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Ready op: visible on exe_* after the second edge, station empties.
    set_alloc(3, 0, 0, 32'd5, 32'd7);
    step("t2.a");
    idle();
    step("t2.b");
    check("t2.valid", 64'(exe_valid), 64'd1);
    check("t2.dest",  64'(exe_dest),  64'd3);
    check("t2.vj",    64'(exe_vj),    64'd5);
    check("t2.vk",    64'(exe_vk),    64'd7);
    check("t2.count", 64'(count),     64'd0);

    // Waiting op A is overtaken by younger ready op B, then woken by cdb0.
    set_alloc(4, 9, 0, 0, 32'd1);
    step("t3.a");
    set_alloc(5, 0, 0, 32'd2, 32'd3);
    step("t3.b");
    idle();
    cdb_dest = {TAG_W'(0), TAG_W'(9)};
    cdb_value = {32'd0, 32'h11};
    step("t3.c");
    check("t3.first", 64'(exe_dest), 64'd5);
    idle();
    step("t3.d");
    check("t3.second", 64'(exe_dest), 64'd4);
    check("t3.vj",     64'(exe_vj),   64'h11);

    // Same-cycle bypass from cdb1 into the op being allocated.
    set_alloc(7, 0, 6, 32'd9, 32'd0);
    cdb_dest = {TAG_W'(6), TAG_W'(0)};
    cdb_value = {32'hAB, 32'd0};
    step("t4.a");
    idle();
    step("t4.b");
    check("t4.dest", 64'(exe_dest), 64'd7);
    check("t4.vk",   64'(exe_vk),   64'hAB);
    step("t4.c");
    step("t4.d");

    // Fill with a stalled FU: one op sits in exe, sixteen fill the station.
    exe_ready = 1'b0;
    for (int k = 1; k <= DEPTH + 2; k++) begin
      set_alloc(TAG_W'(k), 0, 0, 32'(k), 32'(k));
      step("t5.fill");
    end
    check("t5.full",  64'(full),  64'd1);
    check("t5.count", 64'(count), 64'd16);
    idle();
    for (int k = 0; k < 3; k++) begin
      step("t5.hold");
      check("t5.hold_dest", 64'(exe_dest), 64'd1);
    end
    exe_ready = 1'b1;
    step("t5.release");
    check("t5.oldest", 64'(exe_dest), 64'd2);
    check("t5.unfull", 64'(full),     64'd0);
    check("t5.count2", 64'(count),    64'd15);
    for (int k = 0; k < DEPTH + 2; k++) step("t5.drain");

    // Flush with a pending exe op; rdy=0 first must hold everything.
    exe_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      set_alloc(TAG_W'(k + 10), 0, 0, 32'(k), 32'(k));
      step("t6.fill");
    end
    flush = 1'b1;
    set_alloc(30, 0, 0, 0, 0);
    rdy = 1'b0;
    step("t6.frozen1");
    step("t6.frozen2");
    check("t6.frz_count", 64'(count),     64'd5);
    check("t6.frz_valid", 64'(exe_valid), 64'd1);
    rdy = 1'b1;
    step("t6.flush");
    check("t6.count", 64'(count),     64'd0);
    check("t6.valid", 64'(exe_valid), 64'd0);
    idle();
    exe_ready = 1'b1;
    step("t6.after");
    check("t6.noalloc", 64'(count), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      rdy       = ($urandom % 10) != 0;
      flush     = ($urandom % 64) == 0;
      exe_ready = ($urandom % 10) < 7;
      if (($urandom % 10) < 6)
        set_alloc(TAG_W'(1 + $urandom % 31),
                  (($urandom % 3) == 0) ? TAG_W'(0) : TAG_W'(1 + $urandom % 7),
                  (($urandom % 3) == 0) ? TAG_W'(0) : TAG_W'(1 + $urandom % 7),
                  $urandom, $urandom);
      else
        alloc_valid = 1'b0;
      t0 = ($urandom % 2) ? TAG_W'(1 + $urandom % 7) : TAG_W'(0);
      t1 = ($urandom % 2) ? TAG_W'(1 + $urandom % 7) : TAG_W'(0);
      if (t1 == t0) t1 = '0;
      cdb_dest  = {t1, t0};
      cdb_value = {$urandom, $urandom};
      step("rand");
    end

    // Asynchronous reset mid-cycle while the station is busy.
    exe_ready = 1'b0;
    idle();
    for (int k = 1; k <= 4; k++) begin
      set_alloc(TAG_W'(k), 0, 0, 32'(k), 32'(k));
      step("t1.fill");
    end
    idle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("t1.async");
    #2 rst = 1'b0;
    exe_ready = 1'b1;
    step("t1.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
